// File: rtl/mfp_ahb_ram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port AHB-Lite RAM slave.
// Optional bus locking with a starvation bound is enabled by defining MFP_RAM_ARB_LOCK_EN.
module mfp_ahb_ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int LOCK_MAX   = 8
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  r0_req,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic                  r0_write,
  input  logic [2:0]            r0_size,
  input  logic [31:0]           r0_wdata,
  input  logic                  r0_lock,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [31:0]           r0_rdata,
  input  logic                  r1_req,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic                  r1_write,
  input  logic [2:0]            r1_size,
  input  logic [31:0]           r1_wdata,
  input  logic                  r1_lock,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [31:0]           r1_rdata,
  output logic                  HSEL,
  output logic [ADDR_WIDTH-1:0] HADDR,
  output logic [1:0]            HTRANS,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [31:0]           HWDATA,
  input  logic [31:0]           HRDATA
);

  logic                  r_last;
  logic                  r_dpValid;
  logic                  r_dpOwner;
  logic                  r_dpWrite;
  logic [31:0]           r_dpWdata;
  logic [ADDR_WIDTH-1:0] r_haddr;
  logic                  r_hwrite;
  logic [2:0]            r_hsize;

  logic                  w_rrGnt0;
  logic                  w_rrGnt1;
  logic                  w_gnt0;
  logic                  w_gnt1;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_winAddr;
  logic                  w_winWrite;
  logic [2:0]            w_winSize;
  logic [2:0]            w_winSizeRaw;
  logic [31:0]           w_winWdata;

  // Round-robin: on contention the requester that did not win last time goes first.
  always_comb begin
    w_rrGnt0 = 1'b0;
    w_rrGnt1 = 1'b0;
    if (!HRESET) begin
      if (r0_req && r1_req) begin
        w_rrGnt0 = r_last;
        w_rrGnt1 = ~r_last;
      end else begin
        w_rrGnt0 = r0_req;
        w_rrGnt1 = r1_req;
      end
    end
  end

`ifdef MFP_RAM_ARB_LOCK_EN
  typedef enum logic [1:0] {OPEN, LOCKED0, LOCKED1} lockState_t;

  localparam int CW = $clog2(LOCK_MAX + 1);

  lockState_t    r_state;
  lockState_t    w_stateNext;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cntNext;
  logic [CW-1:0] w_cntBase;
  logic [CW-1:0] w_cntInc;
  logic          w_winLock;
  logic          w_otherWaits;

  always_comb begin
    w_gnt0 = w_rrGnt0;
    w_gnt1 = w_rrGnt1;
    if (r_state == LOCKED0 && r0_req) begin
      w_gnt0 = ~HRESET;
      w_gnt1 = 1'b0;
    end else if (r_state == LOCKED1 && r1_req) begin
      w_gnt0 = 1'b0;
      w_gnt1 = ~HRESET;
    end
  end

  // The count only carries over while the same owner keeps the lock; any change of owner restarts it.
  always_comb begin
    w_winLock    = w_gnt1 ? r1_lock : r0_lock;
    w_otherWaits = w_gnt1 ? r0_req : r1_req;
    w_cntBase    = ((r_state == LOCKED0 && w_gnt0) || (r_state == LOCKED1 && w_gnt1)) ? r_cnt : '0;
    w_cntInc     = w_cntBase + CW'(1);
    w_stateNext  = r_state;
    w_cntNext    = r_cnt;
    if (w_gnt0 || w_gnt1) begin
      if (!w_winLock) begin
        w_stateNext = OPEN;
        w_cntNext   = '0;
      end else if (!w_otherWaits) begin
        w_stateNext = w_gnt1 ? LOCKED1 : LOCKED0;
        w_cntNext   = w_cntBase;
      end else if (w_cntInc == CW'(LOCK_MAX)) begin
        w_stateNext = OPEN;
        w_cntNext   = '0;
      end else begin
        w_stateNext = w_gnt1 ? LOCKED1 : LOCKED0;
        w_cntNext   = w_cntInc;
      end
    end else if (r_state != OPEN) begin
      w_stateNext = OPEN;
      w_cntNext   = '0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state <= OPEN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end
`else
  logic w_unused;

  assign w_unused = r0_lock ^ r1_lock ^ (LOCK_MAX > 0);

  always_comb begin
    w_gnt0 = w_rrGnt0;
    w_gnt1 = w_rrGnt1;
  end
`endif

  assign w_grant      = w_gnt0 | w_gnt1;
  assign w_winAddr    = w_gnt1 ? r1_addr  : r0_addr;
  assign w_winWrite   = w_gnt1 ? r1_write : r0_write;
  assign w_winSizeRaw = w_gnt1 ? r1_size  : r0_size;
  assign w_winWdata   = w_gnt1 ? r1_wdata : r0_wdata;
  assign w_winSize    = (w_winSizeRaw > 3'd2) ? 3'd2 : w_winSizeRaw;

  // Address-phase controls are remembered so an idle bus keeps presenting the last transfer.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_last    <= 1'b1;
      r_dpValid <= 1'b0;
      r_dpOwner <= 1'b0;
      r_dpWrite <= 1'b0;
      r_dpWdata <= '0;
      r_haddr   <= '0;
      r_hwrite  <= 1'b0;
      r_hsize   <= 3'd2;
    end else begin
      r_dpValid <= w_grant;
      if (w_grant) begin
        r_last    <= w_gnt1;
        r_dpOwner <= w_gnt1;
        r_dpWrite <= w_winWrite;
        r_dpWdata <= w_winWdata;
        r_haddr   <= w_winAddr;
        r_hwrite  <= w_winWrite;
        r_hsize   <= w_winSize;
      end
    end
  end

  assign r0_gnt    = w_gnt0;
  assign r1_gnt    = w_gnt1;
  assign HSEL      = w_grant;
  assign HTRANS    = w_grant ? 2'b10 : 2'b00;
  assign HADDR     = w_grant ? w_winAddr  : r_haddr;
  assign HWRITE    = w_grant ? w_winWrite : r_hwrite;
  assign HSIZE     = w_grant ? w_winSize  : r_hsize;
  assign HBURST    = 3'b000;
  assign HWDATA    = r_dpWdata;

  // A read still in its data phase when reset arrives is dropped.
  assign r0_rvalid = ~HRESET & r_dpValid & ~r_dpWrite & ~r_dpOwner;
  assign r1_rvalid = ~HRESET & r_dpValid & ~r_dpWrite & r_dpOwner;
  assign r0_rdata  = HRDATA;
  assign r1_rdata  = HRDATA;

endmodule

// File: tb/tb_mfp_ahb_ram_arbiter.sv
// Directed testbench for mfp_ahb_ram_arbiter with a small behavioural AHB RAM behind it.
// The lock scenario expectations follow MFP_RAM_ARB_LOCK_EN with LOCK_MAX=3.
module tb_mfp_ahb_ram_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        r0_req, r0_write, r0_lock, r0_gnt, r0_rvalid;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic [2:0]  r0_size;
  logic        r1_req, r1_write, r1_lock, r1_gnt, r1_rvalid;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [2:0]  r1_size;
  logic        HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;

  int nCompared = 0;
  int nMismatched = 0;

  always #5 HCLK = ~HCLK;

  mfp_ahb_ram_arbiter #(.ADDR_WIDTH(32), .LOCK_MAX(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_write(r0_write), .r0_size(r0_size),
    .r0_wdata(r0_wdata), .r0_lock(r0_lock), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_write(r1_write), .r1_size(r1_size),
    .r1_wdata(r1_wdata), .r1_lock(r1_lock), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HBURST(HBURST), .HWDATA(HWDATA), .HRDATA(HRDATA)
  );

  // Behavioural single-port RAM: captures the address phase, writes byte lanes in the data phase.
  logic [31:0] mem [0:63];
  logic        ramDpSel = 1'b0;
  logic        ramDpWr = 1'b0;
  logic [31:0] ramDpAddr = '0;
  logic [2:0]  ramDpSize = 3'd2;
  logic [3:0]  ramMask;

  always_comb begin
    ramMask = 4'b1111;
    if (ramDpSize == 3'd0) ramMask = 4'b0001 << ramDpAddr[1:0];
    else if (ramDpSize == 3'd1) ramMask = ramDpAddr[1] ? 4'b1100 : 4'b0011;
  end

  always @(posedge HCLK) begin
    if (ramDpSel && ramDpWr)
      for (int b = 0; b < 4; b++)
        if (ramMask[b]) mem[ramDpAddr[7:2]][8*b +: 8] <= HWDATA[8*b +: 8];
    ramDpSel  <= HSEL && (HTRANS == 2'b10);
    ramDpWr   <= HWRITE;
    ramDpAddr <= HADDR;
    ramDpSize <= HSIZE;
  end

  assign HRDATA = mem[ramDpAddr[7:2]];

  task tick;
    @(posedge HCLK);
    #1;
  endtask

  task idleInputs;
    r0_req = 0; r0_addr = '0; r0_write = 0; r0_size = 3'd2; r0_wdata = '0; r0_lock = 0;
    r1_req = 0; r1_addr = '0; r1_write = 0; r1_size = 3'd2; r1_wdata = '0; r1_lock = 0;
  endtask

  task test_reset;
    HRESET = 1;
    idleInputs();
    repeat (3) tick();
    r0_req = 1; r1_req = 1;
    @(negedge HCLK);
    nCompared++; if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_gnt: got %b%b want 00", r0_gnt, r1_gnt); end
    nCompared++; if (HSEL !== 1'b0 || HTRANS !== 2'b00) begin nMismatched++; $display("[TB] FAIL reset_hsel: got sel=%b trans=%b want 0/00", HSEL, HTRANS); end
    nCompared++; if (HADDR !== 32'h0 || HWRITE !== 1'b0 || HSIZE !== 3'd2 || HWDATA !== 32'h0) begin nMismatched++; $display("[TB] FAIL reset_bus: got addr=%h wr=%b size=%0d wdata=%h want 0/0/2/0", HADDR, HWRITE, HSIZE, HWDATA); end
    nCompared++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0 || HBURST !== 3'b000) begin nMismatched++; $display("[TB] FAIL reset_rvalid: got %b%b burst=%b want 00/000", r0_rvalid, r1_rvalid, HBURST); end
    tick();
  endtask

  task test_single_read;
    HRESET = 0;
    idleInputs();
    r0_req = 1; r0_addr = 32'h10;
    @(negedge HCLK);
    nCompared++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL read_gnt: got %b%b want 10", r0_gnt, r1_gnt); end
    nCompared++; if (HSEL !== 1'b1 || HTRANS !== 2'b10 || HADDR !== 32'h10 || HWRITE !== 1'b0) begin nMismatched++; $display("[TB] FAIL read_addr_phase: got sel=%b trans=%b addr=%h wr=%b want 1/10/00000010/0", HSEL, HTRANS, HADDR, HWRITE); end
    tick();
    r0_req = 0;
    @(negedge HCLK);
    nCompared++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h12345678) begin nMismatched++; $display("[TB] FAIL read_data: got v=%b d=%h want 1/12345678", r0_rvalid, r0_rdata); end
    nCompared++; if (r1_rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL read_r1_rvalid: got %b want 0", r1_rvalid); end
    tick();
  endtask

  task test_no_request;
    idleInputs();
    @(negedge HCLK);
    nCompared++; if (HSEL !== 1'b0 || HTRANS !== 2'b00 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_bus: got sel=%b trans=%b gnt=%b%b want 0/00/00", HSEL, HTRANS, r0_gnt, r1_gnt); end
    nCompared++; if (r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL idle_rvalid: got %b%b want 00", r0_rvalid, r1_rvalid); end
    nCompared++; if (HADDR !== 32'h10 || HSIZE !== 3'd2) begin nMismatched++; $display("[TB] FAIL idle_hold: got addr=%h size=%0d want 00000010/2", HADDR, HSIZE); end
    tick();
  endtask

  task test_back_to_back;
    logic prevR0;
    HRESET = 1;
    idleInputs();
    tick();
    HRESET = 0;
    r0_req = 1; r0_addr = 32'h10;
    r1_req = 1; r1_addr = 32'h4;
    prevR0 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge HCLK);
      nCompared++; if (r0_gnt !== (i % 2 == 0) || r1_gnt !== (i % 2 == 1) || HSEL !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_gnt[%0d]: got %b%b sel=%b want %b%b/1", i, r0_gnt, r1_gnt, HSEL, (i % 2 == 0), (i % 2 == 1)); end
      nCompared++; if (HADDR !== ((i % 2 == 0) ? 32'h10 : 32'h4)) begin nMismatched++; $display("[TB] FAIL b2b_addr[%0d]: got %h want %h", i, HADDR, (i % 2 == 0) ? 32'h10 : 32'h4); end
      if (i > 0) begin
        nCompared++; if (r0_rvalid !== prevR0 || r1_rvalid !== ~prevR0) begin nMismatched++; $display("[TB] FAIL b2b_rvalid[%0d]: got %b%b want %b%b", i, r0_rvalid, r1_rvalid, prevR0, ~prevR0); end
        nCompared++; if (r0_rdata !== (prevR0 ? 32'h12345678 : 32'h11223344)) begin nMismatched++; $display("[TB] FAIL b2b_rdata[%0d]: got %h want %h", i, r0_rdata, prevR0 ? 32'h12345678 : 32'h11223344); end
      end
      prevR0 = (i % 2 == 0);
      tick();
    end
    idleInputs();
    tick();
  endtask

  task test_size_clamp;
    idleInputs();
    r0_req = 1; r0_addr = 32'h10; r0_size = 3'd7;
    @(negedge HCLK);
    nCompared++; if (HSIZE !== 3'd2 || r0_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL size_clamp: got size=%0d gnt=%b want 2/1", HSIZE, r0_gnt); end
    tick();
    idleInputs();
    tick();
  endtask

  task test_write_then_read;
    idleInputs();
    r1_req = 1; r1_addr = 32'h5; r1_write = 1; r1_size = 3'd0; r1_wdata = 32'h0000AB00;
    @(negedge HCLK);
    nCompared++; if (r1_gnt !== 1'b1 || HWRITE !== 1'b1 || HSIZE !== 3'd0 || HADDR !== 32'h5) begin nMismatched++; $display("[TB] FAIL wr_addr_phase: got gnt=%b wr=%b size=%0d addr=%h want 1/1/0/00000005", r1_gnt, HWRITE, HSIZE, HADDR); end
    tick();
    idleInputs();
    r0_req = 1; r0_addr = 32'h4;
    @(negedge HCLK);
    nCompared++; if (HWDATA[15:8] !== 8'hAB) begin nMismatched++; $display("[TB] FAIL wr_hwdata: got %h want AB", HWDATA[15:8]); end
    nCompared++; if (r0_gnt !== 1'b1 || HWRITE !== 1'b0 || HADDR !== 32'h4 || r1_rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rd_after_wr: got gnt=%b wr=%b addr=%h r1v=%b want 1/0/00000004/0", r0_gnt, HWRITE, HADDR, r1_rvalid); end
    tick();
    idleInputs();
    @(negedge HCLK);
    nCompared++; if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h1122AB44) begin nMismatched++; $display("[TB] FAIL rd_merged: got v=%b d=%h want 1/1122ab44", r0_rvalid, r0_rdata); end
    tick();
  endtask

  task test_reset_mid;
    idleInputs();
    r0_req = 1; r0_addr = 32'h10;
    @(negedge HCLK);
    nCompared++; if (r0_gnt !== 1'b1) begin nMismatched++; $display("[TB] FAIL mid_gnt: got %b want 1", r0_gnt); end
    tick();
    HRESET = 1;
    r1_req = 1; r1_addr = 32'h4;
    @(negedge HCLK);
    nCompared++; if (r0_rvalid !== 1'b0 || r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || HSEL !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_drop: got rv=%b gnt=%b%b sel=%b want 0/00/0", r0_rvalid, r0_gnt, r1_gnt, HSEL); end
    tick();
    @(negedge HCLK);
    nCompared++; if (HADDR !== 32'h0 || HWDATA !== 32'h0 || HSIZE !== 3'd2 || r0_rvalid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_regs: got addr=%h wdata=%h size=%0d rv=%b want 0/0/2/0", HADDR, HWDATA, HSIZE, r0_rvalid); end
    tick();
    HRESET = 0;
    @(negedge HCLK);
    nCompared++; if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_first_gnt: got %b%b want 10", r0_gnt, r1_gnt); end
    tick();
    idleInputs();
    tick();
  endtask

  task test_lock;
    logic [4:0] expR1;
`ifdef MFP_RAM_ARB_LOCK_EN
    expR1 = 5'b01000;
`else
    expR1 = 5'b01010;
`endif
    HRESET = 1;
    idleInputs();
    tick();
    HRESET = 0;
    r0_req = 1; r0_addr = 32'h10; r0_lock = 1;
    r1_req = 1; r1_addr = 32'h4;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      nCompared++; if (r1_gnt !== expR1[i] || r0_gnt !== ~expR1[i]) begin nMismatched++; $display("[TB] FAIL lock_seq[%0d]: got %b%b want %b%b", i, r0_gnt, r1_gnt, ~expR1[i], expR1[i]); end
      tick();
    end
    idleInputs();
    tick();
  endtask

  initial begin
    for (int w = 0; w < 64; w++) mem[w] = '0;
    mem[4] = 32'h12345678;
    mem[1] = 32'h11223344;
    test_reset();
    test_single_read();
    test_no_request();
    test_back_to_back();
    test_size_clamp();
    test_write_then_read();
    test_reset_mid();
    test_lock();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
